// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that shares the write port of one synchronous FIFO
// between N_REQ producers. The winning producer owns the FIFO for a burst of
// up to MAX_BURST words. After that the search for the next owner starts just
// past it, so a producer that stays valid is only re-granted when no other
// producer is valid. One IDLE cycle always separates two bursts.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset; also blocks writes in its cycle
//   req_valid   per-producer word valid
//   req_data    flat producer data, producer i at [i*WIDTH +: WIDTH]
//   req_ready   per-producer accept (combinational); transfer = valid & ready
//   fifo_full   FIFO full flag
//   fifo_wr_en  FIFO write enable (combinational, never high while full)
//   fifo_din    FIFO write data (combinational mux of the owner's data)
//   grant       registered one-hot owner, zero when idle
//   owner_id    registered binary index of the owner
//   busy        high while in BURST
//
// States
//   state | meaning
//   IDLE  | no owner; choose next owner round-robin from last+1
//   BURST | owner_id writes words until MAX_BURST words or valid drops
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_din,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   owner_id,
    output logic                       busy
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  burst_cnt;
    logic [ID_W-1:0]   last_ptr;

    logic              burst_act;
    logic              owner_valid;
    logic              xfer;
    logic              last_word;
    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   cand;

    // rst is synchronous, but a word offered in the reset cycle must not be
    // accepted, so the handshake is gated by rst as well.
    assign burst_act   = (state == BURST) && !rst;
    assign owner_valid = req_valid[owner_id];
    assign xfer        = burst_act && owner_valid && !fifo_full;
    assign last_word   = (burst_cnt == CNT_W'(MAX_BURST - 1));

    assign busy        = (state == BURST);
    assign fifo_wr_en  = xfer;
    assign fifo_din    = req_data[int'(owner_id)*WIDTH +: WIDTH];

    always_comb begin
        req_ready = '0;
        if (burst_act && !fifo_full) begin
            req_ready[owner_id] = 1'b1;
        end
    end

    // Round-robin search: first valid producer at last+1, last+2, ... mod N_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(last_ptr) + k) % N_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            owner_id  <= '0;
            burst_cnt <= '0;
            last_ptr  <= ID_W'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= BURST;
                        grant     <= N_REQ'(1) << pick_id;
                        owner_id  <= pick_id;
                        burst_cnt <= '0;
                    end
                end
                BURST: begin
                    if (!owner_valid) begin
                        // Owner withdrew: it gives up the rest of its burst.
                        state    <= IDLE;
                        grant    <= '0;
                        last_ptr <= owner_id;
                    end else if (!fifo_full) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                        if (last_word) begin
                            state    <= IDLE;
                            grant    <= '0;
                            last_ptr <= owner_id;
                        end
                    end
                    // Full with owner valid: stall, everything held.
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule
